// File: rtl/eval_sequencer.sv
// eval_sequencer: scans the expression buffer after an eval pulse and streams
// number/operator/end tokens to the evaluator over a valid/ready handshake.
// Optional build macro EVAL_PAREN_CHECK_EN adds parenthesis-balance checking.
module eval_sequencer #(
  parameter int depth = 20,
  parameter int width = 8,
  parameter int opw   = 16,
  parameter int aw    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             eval,
  output logic [aw-1:0]    rd_addr,
  input  logic [width-1:0] rd_data,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic             tok_is_num,
  output logic [opw-1:0]   tok_value,
  output logic             tok_last,
  output logic             lock,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, DECODE, EMIT_NUM, EMIT_OP, EMIT_END, DONE
  } state_t;

  localparam logic [width-1:0] C_NINE  = width'(9);
  localparam logic [width-1:0] C_OPLO  = width'(10);
  localparam logic [width-1:0] C_OPHI  = width'(15);
  localparam logic [width-1:0] C_EMPTY = width'(255);
  localparam logic [aw-1:0]    LAST    = aw'(depth - 1);

  state_t           state;
  logic [aw-1:0]    idx;
  logic [opw-1:0]   acc;
  logic             have_num;
  logic             end_pend;   // pending number flush leads to end token
  logic [width-1:0] op_code;
  logic [width-1:0] slot;       // buffer contents captured after read latency

  logic             is_digit, is_op, is_end;
  logic [opw+3:0]   acc_wide, acc_next;
  logic             ovf;
  logic             close_bad, end_bad;

  assign is_digit = (slot <= C_NINE);
  assign is_op    = (slot >= C_OPLO) && (slot <= C_OPHI);
  assign is_end   = (slot == C_EMPTY);

  // acc*10 + d computed exactly in 4 extra bits; any upper bit means overflow
  assign acc_wide = {4'd0, acc};
  assign acc_next = (acc_wide << 3) + (acc_wide << 1) + {{opw{1'b0}}, slot[3:0]};
  assign ovf      = (acc_next[opw+3:opw] != 4'd0);

`ifdef EVAL_PAREN_CHECK_EN
  localparam logic [width-1:0] C_LPAR = width'(14);
  localparam logic [width-1:0] C_RPAR = width'(15);
  logic [aw-1:0] pdepth;

  // paren nesting depth, restarted on each accepted eval
  always_ff @(posedge clock) begin
    if (!reset)                                   pdepth <= '0;
    else if (state == IDLE && eval)               pdepth <= '0;
    else if (state == DECODE && slot == C_LPAR)   pdepth <= pdepth + 1'b1;
    else if (state == DECODE && slot == C_RPAR && pdepth != '0)
                                                  pdepth <= pdepth - 1'b1;
  end

  assign close_bad = (slot == C_RPAR) && (pdepth == '0);
  assign end_bad   = (pdepth != '0);
`else
  assign close_bad = 1'b0;
  assign end_bad   = 1'b0;
`endif

  // scan FSM with registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      have_num   <= 1'b0;
      end_pend   <= 1'b0;
      op_code    <= '0;
      slot       <= '0;
      rd_addr    <= '0;
      tok_valid  <= 1'b0;
      tok_is_num <= 1'b0;
      tok_value  <= '0;
      tok_last   <= 1'b0;
      lock       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (eval) begin
          idx      <= '0;
          acc      <= '0;
          have_num <= 1'b0;
          end_pend <= 1'b0;
          err      <= 1'b0;
          lock     <= 1'b1;
          rd_addr  <= '0;
          state    <= FETCH;
        end
        FETCH: state <= WAIT;
        WAIT: begin
          slot  <= rd_data;
          state <= DECODE;
        end
        DECODE: begin
          if (is_digit) begin
            if (ovf) begin
              err   <= 1'b1;
              lock  <= 1'b0;
              state <= DONE;
            end else begin
              acc      <= acc_next[opw-1:0];
              have_num <= 1'b1;
              idx      <= idx + 1'b1;
              if (idx == LAST) begin
                // buffer exhausted: flush the number, then the end token
                end_pend   <= 1'b1;
                tok_valid  <= 1'b1;
                tok_is_num <= 1'b1;
                tok_value  <= acc_next[opw-1:0];
                tok_last   <= 1'b0;
                state      <= EMIT_NUM;
              end else begin
                rd_addr <= idx + 1'b1;
                state   <= FETCH;
              end
            end
          end else if (is_op && !close_bad) begin
            op_code   <= slot;
            tok_valid <= 1'b1;
            tok_last  <= 1'b0;
            if (have_num) begin
              end_pend   <= 1'b0;
              tok_is_num <= 1'b1;
              tok_value  <= acc;
              state      <= EMIT_NUM;
            end else begin
              tok_is_num <= 1'b0;
              tok_value  <= opw'(slot);
              state      <= EMIT_OP;
            end
          end else if (is_end && have_num) begin
            end_pend   <= 1'b1;
            tok_valid  <= 1'b1;
            tok_is_num <= 1'b1;
            tok_value  <= acc;
            tok_last   <= 1'b0;
            state      <= EMIT_NUM;
          end else if (is_end && !end_bad) begin
            tok_valid  <= 1'b1;
            tok_is_num <= 1'b0;
            tok_value  <= '0;
            tok_last   <= 1'b1;
            state      <= EMIT_END;
          end else begin
            // invalid code, unmatched ')' or unbalanced end
            err   <= 1'b1;
            lock  <= 1'b0;
            state <= DONE;
          end
        end
        EMIT_NUM: if (tok_ready) begin
          acc      <= '0;
          have_num <= 1'b0;
          if (end_pend && end_bad) begin
            tok_valid <= 1'b0;
            err       <= 1'b1;
            lock      <= 1'b0;
            state     <= DONE;
          end else if (end_pend) begin
            tok_is_num <= 1'b0;
            tok_value  <= '0;
            tok_last   <= 1'b1;
            state      <= EMIT_END;
          end else begin
            tok_is_num <= 1'b0;
            tok_value  <= opw'(op_code);
            state      <= EMIT_OP;
          end
        end
        EMIT_OP: if (tok_ready) begin
          idx <= idx + 1'b1;
          if (idx == LAST && end_bad) begin
            tok_valid <= 1'b0;
            err       <= 1'b1;
            lock      <= 1'b0;
            state     <= DONE;
          end else if (idx == LAST) begin
            tok_value <= '0;
            tok_last  <= 1'b1;
            state     <= EMIT_END;
          end else begin
            tok_valid <= 1'b0;
            rd_addr   <= idx + 1'b1;
            state     <= FETCH;
          end
        end
        EMIT_END: if (tok_ready) begin
          tok_valid <= 1'b0;
          tok_last  <= 1'b0;
          lock      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eval_sequencer.sv
// tb_eval_sequencer: directed and random buffers checked against a
// token-list reference model built by scanning the buffer in software.
module tb_eval_sequencer;
  localparam int DEPTH = 20;
  localparam int W     = 8;
  localparam int OPW   = 16;
  localparam int AW    = 5;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           eval = 1'b0;
  logic           tok_ready = 1'b0;
  logic [W-1:0]   rd_data = '0;
  logic [AW-1:0]  rd_addr;
  logic           tok_valid, tok_is_num, tok_last, lock, done, err;
  logic [OPW-1:0] tok_value;

  eval_sequencer #(.depth(DEPTH), .width(W), .opw(OPW), .aw(AW)) dut (
    .clock(clock), .reset(reset), .eval(eval),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_num(tok_is_num),
    .tok_value(tok_value), .tok_last(tok_last),
    .lock(lock), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  // buffer with one-cycle read latency
  logic [W-1:0] mem [DEPTH];
  always @(posedge clock) rd_data <= (int'(rd_addr) < DEPTH) ? mem[rd_addr] : 8'hFF;

  typedef struct packed { logic is_num; logic last; logic [OPW-1:0] value; } tok_t;
  tok_t exp_q[$];
  tok_t got_q[$];
  bit   exp_err;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic tok_t mk(input bit is_num, input bit last, input int v);
    tok_t t;
    t.is_num = is_num; t.last = last; t.value = OPW'(v);
    return t;
  endfunction

  // reference: parse the buffer into the expected token list
  function automatic void model();
    int  acc;
    int  pd;
    int  c;
    bit  have;
    acc = 0; pd = 0; have = 0;
    exp_q.delete();
    exp_err = 0;
    for (int i = 0; i < DEPTH; i++) begin
      c = int'(mem[i]);
      if (c <= 9) begin
        acc = acc * 10 + c;
        if (acc > 65535) begin exp_err = 1; return; end
        have = 1;
      end else if (c <= 15) begin
`ifdef EVAL_PAREN_CHECK_EN
        if (c == 15 && pd == 0) begin exp_err = 1; return; end
        if (c == 14) pd++;
        if (c == 15) pd--;
`endif
        if (have) exp_q.push_back(mk(1, 0, acc));
        have = 0; acc = 0;
        exp_q.push_back(mk(0, 0, c));
      end else if (c == 255) begin
        break;
      end else begin
        exp_err = 1; return;
      end
    end
    if (have) exp_q.push_back(mk(1, 0, acc));
    if (pd != 0) begin exp_err = 1; return; end
    exp_q.push_back(mk(0, 1, 0));
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
  endtask

  // ready_mode: 0 always ready, 1 stall first token 5 cycles, 2 random
  task automatic run(input int ready_mode, input bit extra_eval, input string name);
    tok_t cur, prev;
    bit   pending;
    int   hold, done_cnt, cyc;
    pending = 0; hold = 0; done_cnt = 0;
    prev = '0;
    model();
    got_q.delete();
    @(negedge clock); eval = 1'b1;
    @(negedge clock); eval = 1'b0;
    check({name, ":lock_on"}, lock, 1);
    check({name, ":err_clr"}, err, 0);
    for (cyc = 0; cyc < 2000; cyc++) begin
      if (done) done_cnt++;
      if (!lock) break;
      if (ready_mode == 0) tok_ready = 1'b1;
      else if (ready_mode == 1) begin
        if (tok_valid && got_q.size() == 0 && hold < 5) begin tok_ready = 1'b0; hold++; end
        else tok_ready = 1'b1;
      end else tok_ready = 1'($urandom_range(0, 1));
      cur = {tok_is_num, tok_last, tok_value};
      if (pending) begin
        check({name, ":valid_held"}, tok_valid, 1);
        check({name, ":hold_value"}, cur, prev);
      end
      if (tok_valid) begin
        if (tok_ready) begin got_q.push_back(cur); pending = 0; end
        else begin pending = 1; prev = cur; end
      end
      eval = (extra_eval && (cyc == 3 || cyc == 10)) ? 1'b1 : 1'b0;
      @(negedge clock);
    end
    eval = 1'b0;
    check({name, ":finished"}, lock, 0);
    check({name, ":ntok"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, ":tok"}, got_q[i], exp_q[i]);
    check({name, ":err"}, err, exp_err);
    check({name, ":done_cnt"}, done_cnt, exp_err ? 0 : 1);
    @(negedge clock);
    check({name, ":done_pulse"}, done, 0);
    check({name, ":idle_lock"}, lock, 0);
    check({name, ":err_sticky"}, err, exp_err);
  endtask

  initial begin
    int r;
    clear_mem();
    // reset state
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_valid", tok_valid, 0);
    check("rst_lock", lock, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_value", tok_value, 0);
    check("rst_last", tok_last, 0);
    check("rst_isnum", tok_is_num, 0);
    reset = 1'b1;
    @(negedge clock);

    // 12 + 3
    clear_mem();
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'h0A; mem[3] = 8'd3;
    run(0, 0, "basic");
    check("basic_tok0", exp_q[0], mk(1, 0, 12));
    run(1, 0, "stall");
    run(2, 1, "eval_ignored");

    // overflow at 65536
    clear_mem();
    mem[0] = 8'd6; mem[1] = 8'd5; mem[2] = 8'd5; mem[3] = 8'd3; mem[4] = 8'd6;
    run(0, 0, "ovf");
    check("ovf_model", exp_err, 1);

    // empty buffer
    clear_mem();
    run(0, 0, "empty");

    // twenty ones overflow
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'd1;
    run(0, 0, "ones");

    // alternating digit/op, no terminator
    for (int i = 0; i < DEPTH; i++) mem[i] = (i % 2 == 0) ? W'(i % 10) : W'(10 + (i % 4));
    run(2, 0, "full");

    // parentheses
    clear_mem();
    mem[0] = 8'h0F;
    run(0, 0, "rpar");
    clear_mem();
    mem[0] = 8'h0E; mem[1] = 8'd4; mem[2] = 8'h0F;
    run(0, 0, "paren");
    clear_mem();
    mem[0] = 8'h0E; mem[1] = 8'd7;
    run(0, 0, "open");

    // invalid code with pending number
    clear_mem();
    mem[0] = 8'd9; mem[1] = 8'h20;
    run(0, 0, "invalid");

    // random buffers
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 50)      mem[i] = W'($urandom_range(0, 9));
        else if (r < 90) mem[i] = W'($urandom_range(10, 15));
        else if (r < 97) mem[i] = 8'hFF;
        else             mem[i] = W'($urandom_range(16, 254));
      end
      run(2, t[0], "rand");
    end

    // reset in the middle of a scan
    clear_mem();
    mem[0] = 8'd4; mem[1] = 8'h0A; mem[2] = 8'd5;
    @(negedge clock); eval = 1'b1;
    @(negedge clock); eval = 1'b0; tok_ready = 1'b0;
    repeat (6) @(negedge clock);
    check("mid_lock_busy", lock, 1);
    reset = 1'b0;
    @(negedge clock);
    check("mid_valid", tok_valid, 0);
    check("mid_lock", lock, 0);
    check("mid_done", done, 0);
    check("mid_err", err, 0);
    check("mid_value", tok_value, 0);
    check("mid_isnum", tok_is_num, 0);
    check("mid_addr", rd_addr, 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("mid_stay_idle", lock, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
